uart_tx: RTL and testbench

- RS-232 serial transmitter, companion to the board's serial receiver. Same line format: 9600 baud from CLK_50M, 8 data bits LSB first, odd parity, then stop.
- Bytes written by on-chip logic go through a small FIFO, are serialised and driven onto RS232_DCE_TXD.
- Sits between user logic (buttons/switches or a loopback of received bytes) and the DCE TXD pin.

---
 rtl/uart_tx.sv | 208 ++++++++++++++++++++
 tb/tb_uart_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx -- RS-232 serial transmitter with a small write FIFO.
//
// Line format: start(0), D0..D7 LSB first, odd parity, stop(1) with a
// configurable stop length in half-bit units. Bytes written by on-chip logic
// are queued in a power-of-two FIFO and sent back to back with no idle gap.
//
// Ports:
//   CLK_50M        in   system clock, all state changes on posedge
//   BTN_SOUTH      in   asynchronous active-high reset
//   TX_DATA[7:0]   in   byte to queue, sampled when TX_WE=1
//   TX_WE          in   write strobe, one byte per cycle while high
//   TX_FULL        out  FIFO full (registered); writes dropped while high
//   TX_BUSY        out  FIFO non-empty or frame in progress (registered)
//   RS232_DCE_TXD  out  serial line, idle high (registered)
module uart_tx #(
  parameter int CLKS_PER_BIT    = 5208,
  parameter int STOP_HALF_BITS  = 2,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic       CLK_50M,
  input  logic       BTN_SOUTH,
  input  logic [7:0] TX_DATA,
  input  logic       TX_WE,
  output logic       TX_FULL,
  output logic       TX_BUSY,
  output logic       RS232_DCE_TXD
);

  localparam int DEPTH       = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W       = FIFO_DEPTH_LOG2 + 1;
  localparam int STOP_CYCLES = (STOP_HALF_BITS * CLKS_PER_BIT) / 2;
  localparam int MAX_CYCLES  = (STOP_CYCLES > CLKS_PER_BIT) ? STOP_CYCLES : CLKS_PER_BIT;
  // 13 bits covers one bit time at 9600 baud; widen only if a long stop
  // setting (e.g. 2 stop bits at default rate) would not fit.
  localparam int BAUD_W      = ($clog2(MAX_CYCLES) > 13) ? $clog2(MAX_CYCLES) : 13;

  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]                 fifo_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic                       full_q, full_d;
  logic                       busy_q, busy_d;
  logic                       wr_acc;
  logic                       pop;
  logic                       fifo_ne;
  logic [7:0]                 head;

  // ---------------------------------------------------------------------------
  // Transmit FSM state
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                par_q, par_d;
  logic                txd_q, txd_d;
  logic                bit_end;
  logic                stop_end;

  assign fifo_ne  = (count_q != '0);
  assign head     = fifo_mem[rd_ptr_q];
  // Full is judged on the registered flag, so a pop in the same cycle does
  // not make room for a write that arrives while full.
  assign wr_acc   = TX_WE & ~full_q;
  assign bit_end  = (baud_q == BIT_LAST);
  assign stop_end = (baud_q == STOP_LAST);

  // Storage array: contents are only meaningful between the pointers, so it
  // carries no reset.
  always_ff @(posedge CLK_50M) begin
    if (wr_acc) fifo_mem[wr_ptr_q] <= TX_DATA;
  end

  // Next-state / datapath
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BAUD_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (fifo_ne) begin
          pop     = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (stop_end) begin
          baud_d = '0;
          // Chain straight into the next frame when data is waiting.
          if (fifo_ne) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase

    // The frame's data is captured only here, so later writes cannot
    // disturb a frame already on the wire.
    if (pop) begin
      shift_d = head;
      par_d   = ~^head;
    end
  end

  // Line driver: registered from the current state, so the line lags the
  // state register by one cycle but every bit keeps its full length.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_q[0];
      S_PARITY: txd_d = par_q;
      default:  txd_d = 1'b1;
    endcase
  end

  // FIFO bookkeeping and registered status flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + FIFO_DEPTH_LOG2'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + FIFO_DEPTH_LOG2'(1);
    count_d = count_q + CNT_W'(wr_acc) - CNT_W'(pop);
    full_d  = (count_d == CNT_FULL);
    busy_d  = (state_d != S_IDLE) | (count_d != '0);
  end

  always_ff @(posedge CLK_50M or posedge BTN_SOUTH) begin
    if (BTN_SOUTH) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      busy_q   <= busy_d;
    end
  end

  assign TX_FULL       = full_q;
  assign TX_BUSY       = busy_q;
  assign RS232_DCE_TXD = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed bench for uart_tx with a shortened bit time.
// u_dut uses one stop bit, u_dut15 uses 1.5 stop bits; the bench's frame
// sampler acts as the receiver on whichever line is selected.
module tb_uart_tx;
  localparam int C = 16;

  logic       gclk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       we, we15;
  logic       full, busy, txd;
  logic       full15, busy15, txd15;
  logic       use15 = 1'b0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 gclk = ~gclk;
  always @(posedge gclk) cyc <= cyc + 1;

  uart_tx #(.CLKS_PER_BIT(C), .STOP_HALF_BITS(2), .FIFO_DEPTH_LOG2(2)) u_dut (
    .CLK_50M(gclk), .BTN_SOUTH(rst), .TX_DATA(din), .TX_WE(we),
    .TX_FULL(full), .TX_BUSY(busy), .RS232_DCE_TXD(txd)
  );

  uart_tx #(.CLKS_PER_BIT(C), .STOP_HALF_BITS(3), .FIFO_DEPTH_LOG2(2)) u_dut15 (
    .CLK_50M(gclk), .BTN_SOUTH(rst), .TX_DATA(din), .TX_WE(we15),
    .TX_FULL(full15), .TX_BUSY(busy15), .RS232_DCE_TXD(txd15)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic line();
    return use15 ? txd15 : txd;
  endfunction

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic write_byte(input logic [7:0] d, input logic to15);
    din = d;
    if (to15) we15 = 1'b1; else we = 1'b1;
    tick();
    we   = 1'b0;
    we15 = 1'b0;
  endtask

  // Returns the edge number after which the start bit first appears.
  task automatic wait_start(output int t);
    int n = 0;
    while (line() !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    chk("start_seen", {31'd0, line()}, 32'd0);
    t = cyc;
  endtask

  // Samples every bit of the frame starting at edge t in the bit centre.
  task automatic rx_frame(input int t, input logic [7:0] exp, input logic exp_par, input string tag);
    logic [7:0] d;
    logic       s0, p, s;
    wait_until(t + C/2);
    s0 = line();
    for (int k = 0; k < 8; k++) begin
      wait_until(t + (k+1)*C + C/2);
      d[k] = line();
    end
    wait_until(t + 9*C + C/2);
    p = line();
    wait_until(t + 10*C + C/2);
    s = line();
    chk({tag, "_start"}, {31'd0, s0}, 32'd0);
    chk({tag, "_data"},  {24'd0, d},  {24'd0, exp});
    chk({tag, "_par"},   {31'd0, p},  {31'd0, exp_par});
    chk({tag, "_stop"},  {31'd0, s},  32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int t, t1, t2, t3, nw;
    logic flag;
    logic [7:0] pv   [3] = '{8'h00, 8'h01, 8'hFF};
    logic       pp   [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0] ov   [5] = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic       ofl  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; we = 1'b0; we15 = 1'b0; din = 8'h00;
    repeat (3) tick();
    chk("rst_txd",  {31'd0, txd},  32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Single byte: latency, framing and busy window
    write_byte(8'h55, 1'b0);
    nw = cyc;
    chk("b55_busy_wr", {31'd0, busy}, 32'd1);
    wait_start(t);
    chk("b55_latency", t - nw, 32'd2);
    rx_frame(t, 8'h55, 1'b1, "b55");
    wait_until(t + 11*C - 2);
    chk("b55_busy_last", {31'd0, busy}, 32'd1);
    tick();
    chk("b55_busy_fall", {31'd0, busy}, 32'd0);
    chk("b55_idle_txd",  {31'd0, txd},  32'd1);
    repeat (4) tick();

    // Parity vectors
    for (int i = 0; i < 3; i++) begin
      write_byte(pv[i], 1'b0);
      wait_start(t);
      rx_frame(t, pv[i], pp[i], "par");
      wait_until(t + 11*C + 2);
      chk("par_idle", {31'd0, busy}, 32'd0);
    end

    // Back-to-back frames with no idle gap
    write_byte(8'hA1, 1'b0);
    write_byte(8'hB2, 1'b0);
    write_byte(8'hC3, 1'b0);
    wait_start(t1);
    rx_frame(t1, 8'hA1, 1'b0, "bA1");
    wait_start(t2);
    chk("b2b_gap1", t2 - t1, 11*C);
    rx_frame(t2, 8'hB2, 1'b1, "bB2");
    wait_start(t3);
    chk("b2b_gap2", t3 - t2, 11*C);
    rx_frame(t3, 8'hC3, 1'b1, "bC3");
    wait_until(t3 + 11*C - 2);
    chk("b2b_busy_last", {31'd0, busy}, 32'd1);
    tick();
    chk("b2b_busy_fall", {31'd0, busy}, 32'd0);
    repeat (4) tick();

    // Overflow: fill while first frame is in START
    write_byte(8'h11, 1'b0);
    nw = cyc;
    tick();
    chk("ovf_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      write_byte(ov[i], 1'b0);
      chk("ovf_full", {31'd0, full}, {31'd0, ofl[i]});
    end
    t1 = nw + 2;
    chk("ovf_in_start", {31'd0, txd}, 32'd0);
    rx_frame(t1, 8'h11, 1'b1, "o11");
    wait_until(t1 + 11*C - 2);
    chk("ovf_full_hold", {31'd0, full}, 32'd1);
    tick();
    chk("ovf_full_fall", {31'd0, full}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      wait_start(t2);
      chk("ovf_gap", t2 - t1, 11*C);
      rx_frame(t2, ov[i], 1'b1, "ovf");
      t1 = t2;
    end
    wait_until(t1 + 11*C);
    flag = 1'b0;
    for (int i = 0; i < 33*C; i++) begin
      if (txd !== 1'b1 || busy !== 1'b0) flag = 1'b1;
      tick();
    end
    chk("ovf_no_extra", {31'd0, flag}, 32'd0);

    // Reset during D3 of 0x3C with two bytes queued
    write_byte(8'h3C, 1'b0);
    write_byte(8'h77, 1'b0);
    write_byte(8'h88, 1'b0);
    wait_start(t);
    wait_until(t + 4*C + C/2);
    chk("rst_d3_bit",  {31'd0, txd},  32'd1);
    chk("rst_pre_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_txd",  {31'd0, txd},  32'd1);
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_full", {31'd0, full}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 30*C; i++) begin
      if (txd !== 1'b1 || busy !== 1'b0) flag = 1'b1;
      tick();
    end
    chk("rst_no_resume", {31'd0, flag}, 32'd0);

    // 1.5 stop bits: two frames back to back, gap = 10 bits + 1.5 bits
    use15 = 1'b1;
    write_byte(8'h5A, 1'b1);
    write_byte(8'h5A, 1'b1);
    wait_start(t1);
    rx_frame(t1, 8'h5A, 1'b1, "s15a");
    wait_start(t2);
    chk("s15_gap", t2 - t1, 10*C + 24);
    rx_frame(t2, 8'h5A, 1'b1, "s15b");
    wait_until(t2 + 10*C + 22);
    chk("s15_busy_last", {31'd0, busy15}, 32'd1);
    tick();
    chk("s15_busy_fall", {31'd0, busy15}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
